// File: rtl/xf100_exu_regfile_pkg.sv
// Shared xf100 core constants and regfile helpers.
// Defines XF100_XLEN, XF100_RFIDX_WIDTH and XF100_RF_DEPTH when the build has
// not already provided them.
// Optional feature macro used by the regfile top: XF100_RF_BYPASS_EN.
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif
`ifndef XF100_RF_DEPTH
`define XF100_RF_DEPTH 32
`endif

package xf100_exu_regfile_pkg;

   localparam int RF_XLEN      = `XF100_XLEN;
   localparam int RF_IDX_W     = `XF100_RFIDX_WIDTH;
   localparam int RF_DEPTH_DEF = `XF100_RF_DEPTH;

   // x0 is hardwired, so every write/set/lookup needs this qualifier
   function automatic logic idx_nz(input logic [RF_IDX_W-1:0] idx);
      return (idx != '0);
   endfunction

endpackage

// File: rtl/xf100_exu_rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 tied low.
// Priority: reset > flush > set > writeback clear.
module xf100_exu_rf_scoreboard
   import xf100_exu_regfile_pkg::*;
#(
   parameter int RF_DEPTH = RF_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [RF_IDX_W-1:0] set_idx,
   input  logic                clr_en,
   input  logic [RF_IDX_W-1:0] clr_idx,
   input  logic                flush,
   input  logic [RF_IDX_W-1:0] rs1_idx,
   input  logic [RF_IDX_W-1:0] rs2_idx,
   input  logic [RF_IDX_W-1:0] rd_idx,
   output logic                rs1_busy,
   output logic                rs2_busy,
   output logic                rd_busy,
   output logic                any_busy
);

   logic [RF_DEPTH-1:0] pend;
   logic [RF_DEPTH-1:0] pend_nxt;

   // clear first so a same-index set re-marks the register
   always_comb begin
      pend_nxt = pend;
      if (clr_en && idx_nz(clr_idx)) pend_nxt[clr_idx] = 1'b0;
      if (set_en && idx_nz(set_idx)) pend_nxt[set_idx] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   // pending vector update; flush also drops a same-cycle set
   always_ff @(posedge clk) begin
      if (rst)        pend <= '0;
      else if (flush) pend <= '0;
      else            pend <= pend_nxt;
   end

   // lookups rely on pend[0] never being set, so index 0 reads not busy
   always_comb begin
      rs1_busy = pend[rs1_idx];
      rs2_busy = pend[rs2_idx];
      rd_busy  = pend[rd_idx];
      any_busy = |pend[RF_DEPTH-1:1];
   end

endmodule

// File: rtl/xf100_exu_regfile.sv
// Integer register file with writeback port, two combinational read ports
// and a pending-write scoreboard for dispatch.
// Optional: define XF100_RF_BYPASS_EN for same-cycle writeback-to-read bypass
// (data and busy lookups; any_busy is never bypassed).
module xf100_exu_regfile
   import xf100_exu_regfile_pkg::*;
#(
   parameter int RF_DEPTH = RF_DEPTH_DEF,
   parameter int XLEN     = RF_XLEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wbck_i_wbck_en,
   input  logic [XLEN-1:0]     wbck_i_wbck_data,
   input  logic [RF_IDX_W-1:0] wbck_i_wbck_rdidx,
   input  logic [RF_IDX_W-1:0] rf_i_rs1_idx,
   input  logic [RF_IDX_W-1:0] rf_i_rs2_idx,
   output logic [XLEN-1:0]     rf_o_rs1_data,
   output logic [XLEN-1:0]     rf_o_rs2_data,
   input  logic                sb_i_set_en,
   input  logic [RF_IDX_W-1:0] sb_i_set_idx,
   input  logic                sb_i_flush,
   input  logic [RF_IDX_W-1:0] sb_i_rd_idx,
   output logic                rf_o_rs1_busy,
   output logic                rf_o_rs2_busy,
   output logic                rf_o_rd_busy,
   output logic                rf_o_any_busy
);

   // x0 is not stored
   logic [XLEN-1:0] regs [RF_DEPTH-1:1];
   logic [XLEN-1:0] rs1_arr;
   logic [XLEN-1:0] rs2_arr;
   logic            sb_rs1_busy;
   logic            sb_rs2_busy;
   logic            sb_rd_busy;
   logic            wr_act;
   logic            hit_rs1;
   logic            hit_rs2;
   logic            hit_rd;

   assign wr_act = wbck_i_wbck_en && idx_nz(wbck_i_wbck_rdidx);

   // architectural state update; writes to x0 are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < RF_DEPTH; i++) regs[i] <= '0;
      end else if (wr_act) begin
         regs[wbck_i_wbck_rdidx] <= wbck_i_wbck_data;
      end
   end

   // registered-state read muxes
   always_comb begin
      rs1_arr = idx_nz(rf_i_rs1_idx) ? regs[rf_i_rs1_idx] : '0;
      rs2_arr = idx_nz(rf_i_rs2_idx) ? regs[rf_i_rs2_idx] : '0;
   end

   xf100_exu_rf_scoreboard #(
      .RF_DEPTH (RF_DEPTH)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (sb_i_set_en),
      .set_idx  (sb_i_set_idx),
      .clr_en   (wbck_i_wbck_en),
      .clr_idx  (wbck_i_wbck_rdidx),
      .flush    (sb_i_flush),
      .rs1_idx  (rf_i_rs1_idx),
      .rs2_idx  (rf_i_rs2_idx),
      .rd_idx   (sb_i_rd_idx),
      .rs1_busy (sb_rs1_busy),
      .rs2_busy (sb_rs2_busy),
      .rd_busy  (sb_rd_busy),
      .any_busy (rf_o_any_busy)
   );

   // bypass hits; a same-cycle set of the same index keeps it busy
`ifdef XF100_RF_BYPASS_EN
   always_comb begin
      hit_rs1 = wr_act && (rf_i_rs1_idx == wbck_i_wbck_rdidx);
      hit_rs2 = wr_act && (rf_i_rs2_idx == wbck_i_wbck_rdidx);
      hit_rd  = wr_act && (sb_i_rd_idx  == wbck_i_wbck_rdidx)
                && !(sb_i_set_en && (sb_i_set_idx == wbck_i_wbck_rdidx));
   end
`else
   always_comb begin
      hit_rs1 = 1'b0;
      hit_rs2 = 1'b0;
      hit_rd  = 1'b0;
   end
`endif

   // output selection: bypassed write data wins over the array
   always_comb begin
      rf_o_rs1_data = hit_rs1 ? wbck_i_wbck_data : rs1_arr;
      rf_o_rs2_data = hit_rs2 ? wbck_i_wbck_data : rs2_arr;
      rf_o_rs1_busy = sb_rs1_busy && !(hit_rs1 &&
                      !(sb_i_set_en && (sb_i_set_idx == rf_i_rs1_idx)));
      rf_o_rs2_busy = sb_rs2_busy && !(hit_rs2 &&
                      !(sb_i_set_en && (sb_i_set_idx == rf_i_rs2_idx)));
      rf_o_rd_busy  = sb_rd_busy && !hit_rd;
   end

endmodule

// File: tb/tb_xf100_exu_regfile.sv
// Self-checking bench for xf100_exu_regfile: a behavioural model predicts each
// cycle's outputs, expectations are queued when stimulus is applied and popped
// when the combinational outputs have settled.
module tb_xf100_exu_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [31:0] wb_data;
   logic [4:0]  wb_idx;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        set_en;
   logic [4:0]  set_idx;
   logic        flush;
   logic [4:0]  rd_idx;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rd_busy;
   logic        any_busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_reg  [32];
   logic [31:0] m_pend;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic        bd;
      logic        ba;
   } exp_t;

   exp_t exp_q[$];

`ifdef XF100_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   xf100_exu_regfile dut (
      .clk               (clk),
      .rst               (rst),
      .wbck_i_wbck_en    (wb_en),
      .wbck_i_wbck_data  (wb_data),
      .wbck_i_wbck_rdidx (wb_idx),
      .rf_i_rs1_idx      (rs1_idx),
      .rf_i_rs2_idx      (rs2_idx),
      .rf_o_rs1_data     (rs1_data),
      .rf_o_rs2_data     (rs2_data),
      .sb_i_set_en       (set_en),
      .sb_i_set_idx      (set_idx),
      .sb_i_flush        (flush),
      .sb_i_rd_idx       (rd_idx),
      .rf_o_rs1_busy     (rs1_busy),
      .rf_o_rs2_busy     (rs2_busy),
      .rf_o_rd_busy      (rd_busy),
      .rf_o_any_busy     (any_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (BYP && wb_en && wb_idx != 0 && idx == wb_idx) return wb_data;
      return (idx == 0) ? 32'h0 : m_reg[idx];
   endfunction

   function automatic logic m_busy(input logic [4:0] idx);
      if (idx == 0) return 1'b0;
      if (BYP && wb_en && idx == wb_idx && !(set_en && set_idx == idx)) return 1'b0;
      return m_pend[idx];
   endfunction

   task automatic idle();
      wb_en   = 1'b0;
      wb_data = 32'h0;
      wb_idx  = 5'd0;
      set_en  = 1'b0;
      set_idx = 5'd0;
      flush   = 1'b0;
      rst     = 1'b0;
   endtask

   // one cycle: queue prediction, compare settled outputs, clock, update model
   task automatic tick();
      exp_t e;
      exp_t o;
      #1;
      e.d1 = m_read(rs1_idx);
      e.d2 = m_read(rs2_idx);
      e.b1 = m_busy(rs1_idx);
      e.b2 = m_busy(rs2_idx);
      e.bd = m_busy(rd_idx);
      e.ba = |m_pend[31:1];
      exp_q.push_back(e);
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd0, 32'd1);
      end else begin
         o = exp_q.pop_front();
         chk("rs1_data", rs1_data, o.d1);
         chk("rs2_data", rs2_data, o.d2);
         chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, o.b1});
         chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, o.b2});
         chk("rd_busy",  {31'd0, rd_busy},  {31'd0, o.bd});
         chk("any_busy", {31'd0, any_busy}, {31'd0, o.ba});
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
         m_pend = 32'h0;
      end else begin
         if (wb_en && wb_idx != 0) m_reg[wb_idx] = wb_data;
         if (flush) begin
            m_pend = 32'h0;
         end else begin
            if (wb_en && wb_idx != 0) m_pend[wb_idx] = 1'b0;
            if (set_en && set_idx != 0) m_pend[set_idx] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'hX;
      m_pend  = 32'hX;
      idle();
      rs1_idx = 5'd0;
      rs2_idx = 5'd0;
      rd_idx  = 5'd0;
      rst     = 1'b1;
      wb_en   = 1'b1;
      wb_idx  = 5'd4;
      wb_data = 32'hAAAA_5555;
      set_en  = 1'b1;
      set_idx = 5'd4;
      @(negedge clk);
      // model is unknown until reset lands, so clock through it before checking
      @(posedge clk);
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_pend = 32'h0;
      @(negedge clk);
      idle();

      // all indices read zero and not busy after reset
      for (int i = 0; i < 32; i++) begin
         rs1_idx = 5'(i);
         rs2_idx = 5'(31 - i);
         rd_idx  = 5'(i);
         tick();
      end

      // x5 write: old value this cycle (unless bypassed), new value next
      rs1_idx = 5'd5; wb_en = 1'b1; wb_idx = 5'd5; wb_data = 32'hDEAD_BEEF;
      tick();
      idle();
      tick();
      chk("x5_landed", rs1_data, 32'hDEAD_BEEF);

      // x0 write and set are dropped
      rs2_idx = 5'd0; wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'h1234;
      set_en = 1'b1; set_idx = 5'd0;
      tick();
      idle();
      tick();
      chk("x0_zero", rs2_data, 32'h0);
      chk("x0_any_busy", {31'd0, any_busy}, 32'd0);

      // set x7, writeback three cycles later
      rs1_idx = 5'd7; rd_idx = 5'd7; set_en = 1'b1; set_idx = 5'd7;
      tick();
      idle();
      tick();
      tick();
      chk("x7_busy_n2", {31'd0, rs1_busy}, 32'd1);
      wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'h0000_0777;
      tick();
      idle();
      tick();
      chk("x7_clear", {31'd0, rs1_busy}, 32'd0);

      // same-cycle set and writeback of x7 keeps it busy
      set_en = 1'b1; set_idx = 5'd7; wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'h7;
      tick();
      idle();
      tick();
      chk("x7_reset_busy", {31'd0, rs1_busy}, 32'd1);
      // set and clear on different indices together
      set_en = 1'b1; set_idx = 5'd20; wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'h17;
      rs2_idx = 5'd20;
      tick();
      idle();
      tick();

      // flush beats a same-cycle set; same-cycle write still lands
      set_en = 1'b1; set_idx = 5'd3;
      tick();
      set_idx = 5'd9;
      tick();
      idle();
      flush = 1'b1; set_en = 1'b1; set_idx = 5'd12;
      wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h55;
      rs1_idx = 5'd3; rs2_idx = 5'd12; rd_idx = 5'd9;
      tick();
      idle();
      tick();
      chk("flush_any", {31'd0, any_busy}, 32'd0);
      chk("flush_x3", rs1_data, 32'h55);

      // reset mid-operation with x10 pending
      wb_en = 1'b1; wb_idx = 5'd10; wb_data = 32'hFF; set_en = 1'b1; set_idx = 5'd10;
      tick();
      idle();
      rs1_idx = 5'd10; rd_idx = 5'd10;
      tick();
      rst = 1'b1; wb_en = 1'b1; wb_idx = 5'd10; wb_data = 32'h77;
      set_en = 1'b1; set_idx = 5'd11;
      tick();
      idle();
      tick();
      chk("rst_x10", rs1_data, 32'h0);
      chk("rst_busy", {31'd0, rs1_busy}, 32'd0);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         wb_en   = ($urandom_range(0, 2) != 0);
         wb_idx  = 5'($urandom_range(0, 31));
         wb_data = $urandom;
         set_en  = ($urandom_range(0, 2) == 0);
         set_idx = 5'($urandom_range(0, 31));
         flush   = ($urandom_range(0, 30) == 0);
         rst     = ($urandom_range(0, 100) == 0);
         rs1_idx = ($urandom_range(0, 3) == 0) ? wb_idx : 5'($urandom_range(0, 31));
         rs2_idx = 5'($urandom_range(0, 31));
         rd_idx  = ($urandom_range(0, 3) == 0) ? set_idx : 5'($urandom_range(0, 31));
         tick();
      end

      if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xf100_exu_regfile.md
Name: xf100_exu_regfile

Overview:
Integer register file at the receiving end of the EXU writeback interface.
- Accepts the single merged writeback port: en, data, rdidx.
- Provides two combinational read ports to decode/dispatch.
- Holds a pending-write scoreboard. Dispatch marks a long-latency destination busy; the matching writeback clears it.
- Sits between the writeback merge and the dispatch/operand-fetch logic.

Parameters:
RF_DEPTH, 32, number of architectural registers; must equal 2**`XF100_RFIDX_WIDTH.
XLEN, `XF100_XLEN, register data width.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
wbck_i_wbck_en  input  1  writeback strobe; one write per cycle.
wbck_i_wbck_data  input  XLEN  writeback data.
wbck_i_wbck_rdidx  input  `XF100_RFIDX_WIDTH  writeback destination index.
rf_i_rs1_idx  input  `XF100_RFIDX_WIDTH  read port 1 index.
rf_i_rs2_idx  input  `XF100_RFIDX_WIDTH  read port 2 index.
rf_o_rs1_data  output  XLEN  read port 1 data (combinational).
rf_o_rs2_data  output  XLEN  read port 2 data (combinational).
sb_i_set_en  input  1  dispatch of a long-latency op; marks its rd pending.
sb_i_set_idx  input  `XF100_RFIDX_WIDTH  index to mark pending.
sb_i_flush  input  1  pipeline flush; clears all pending bits.
sb_i_rd_idx  input  `XF100_RFIDX_WIDTH  dispatching op's rd, for the WAW check.
rf_o_rs1_busy  output  1  rs1 has a pending write.
rf_o_rs2_busy  output  1  rs2 has a pending write.
rf_o_rd_busy  output  1  sb_i_rd_idx has a pending write.
rf_o_any_busy  output  1  OR of all pending bits; used for fence/CSR drain.

Behaviour:
Reset:
- While rst=1 at a clock edge, all registers x1..x31 clear to 0 and all pending bits clear to 0.
- Writes and sets in that cycle are ignored.
- Outputs after reset: data outputs 0 for any index; all busy outputs 0.
Register array:
- x0 is not stored. Reads of index 0 return 0; writes to index 0 are dropped.
Write:
- When wbck_i_wbck_en=1 and rdidx!=0, reg[rdidx] <= data at the clock edge. Visible on the read ports the following cycle.
Read:
- Purely combinational from array state; zero-cycle latency.
- Reading the index being written in the same cycle returns the old value (no bypass by default; see Optional Feature).
Scoreboard: per-register pending bit, bit 0 tied to 0. Next-state priority, highest first:
1. rst: all bits 0.
2. sb_i_flush: all bits 0. A same-cycle set is suppressed; same-cycle writeback still updates the array.
3. sb_i_set_en with idx!=0: bit[idx] <= 1. This wins over a same-cycle clear of the same idx, because the new producer re-marks the register.
4. wbck_i_wbck_en with rdidx!=0: bit[rdidx] <= 0. This applies whether or not the bit was set; a clear of a non-pending bit is legal and harmless.
- Set and clear on different indices in the same cycle both take effect.
Busy outputs:
- Combinational lookup of the registered bits: rs1_busy=bit[rs1_idx], rs2_busy=bit[rs2_idx], rd_busy=bit[sb_i_rd_idx].
- Index 0 always reports not busy.
- rf_o_any_busy = OR of bit[31:1].
Unspecified: x/z on idx inputs while en=0 has no effect.

Optional Feature:
XF100_RF_BYPASS_EN
- Defined: write-through bypass.
  - If wbck_i_wbck_en=1, rdidx!=0 and rsN_idx==rdidx, then rf_o_rsN_data = wbck_i_wbck_data in the same cycle.
  - In that case rf_o_rsN_busy and rf_o_rd_busy also report 0 for that idx, unless sb_i_set_en targets the same idx in the same cycle.
  - rf_o_any_busy is not bypassed.
- Undefined: reads and busy outputs reflect registered state only, giving one extra cycle of writeback-to-use latency.

Decomposition:
- Shared constants stay in xf100_defines.v: XF100_XLEN and XF100_RFIDX_WIDTH. Add XF100_RF_DEPTH there.
- No typedef package is needed.
- One sub-module: xf100_exu_rf_scoreboard. It holds the 32-bit pending vector, the set/clear/flush priority, busy lookups and any_busy.
- The top level holds the array, the read muxes and the optional bypass.

Test Plan:
- Reset, then read all 32 indices -> all data 0, all busy 0, any_busy 0.
- Write x5=0xDEADBEEF at cycle N with rs1_idx=5 -> rs1_data old value (0) at N, 0xDEADBEEF at N+1. With XF100_RF_BYPASS_EN: 0xDEADBEEF at N.
- Write x0=0x1234 with set_en for idx 0, read rs2_idx=0 -> rs2_data=0, rs2_busy=0, any_busy=0.
- set x7 at N; writeback x7 at N+3 -> rs1_busy(7)=1 in cycles N+1..N+3 and 0 at N+4. Set x7 and writeback x7 in the same cycle -> busy stays 1.
- set x3 and x9, then flush together with set x12 -> all busy 0 and any_busy 0 next cycle. A same-cycle write of x3=0x55 still lands.
- Assert rst mid-operation while x10 is pending and x10=0xFF -> next cycle x10 reads 0, busy 0, and the same-cycle write is ignored.
